// File: rtl/ula_8bits.sv
// ula_8bits: 8-bit registered ALU with 16 arithmetic and 16 logic functions.
// Operands are accepted on a rising clk edge while in_valid is high, and
// results are visible one cycle later. Outputs hold until the next accept.
// Optional status outputs (zero, neg, ovf) are enabled by defining the macro
// ULA_STATUS_FLAGS_EN.
module ula_8bits (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       c_in,
   output logic [7:0] f,
   output logic       c_out,
   output logic       a_eq_b,
`ifdef ULA_STATUS_FLAGS_EN
   output logic       zero,
   output logic       neg,
   output logic       ovf,
`endif
   output logic       out_valid
);

   logic [7:0] p;
   logic [7:0] q;
   logic [8:0] sum;
   logic [7:0] logic_res;
   logic [7:0] f_next;
   logic       c_next;

   // Pick the two adder operands for the selected arithmetic function
   always_comb begin
      p = a;
      q = 8'h00;
      case (s)
         4'b0000: begin p = a;         q = 8'h00;    end
         4'b0001: begin p = a;         q = b;        end
         4'b0010: begin p = a;         q = ~b;       end
         4'b0011: begin p = a;         q = 8'hFF;    end
         4'b0100: begin p = a;         q = a;        end
         4'b0101: begin p = a | b;     q = 8'h00;    end
         4'b0110: begin p = a | ~b;    q = 8'h00;    end
         4'b0111: begin p = a & b;     q = 8'hFF;    end
         4'b1000: begin p = a;         q = a & b;    end
         4'b1001: begin p = a;         q = a & ~b;   end
         4'b1010: begin p = a | b;     q = a & ~b;   end
         4'b1011: begin p = a & ~b;    q = 8'hFF;    end
         4'b1100: begin p = a | ~b;    q = a & b;    end
         4'b1101: begin p = 8'h00;     q = b;        end
         4'b1110: begin p = ~a;        q = b;        end
         4'b1111: begin p = 8'hFF;     q = 8'h00;    end
         default: begin p = a;         q = 8'h00;    end
      endcase
   end

   // Bitwise function table used in logic mode
   always_comb begin
      logic_res = 8'h00;
      case (s)
         4'b0000: logic_res = ~a;
         4'b0001: logic_res = ~(a | b);
         4'b0010: logic_res = ~a & b;
         4'b0011: logic_res = 8'h00;
         4'b0100: logic_res = ~(a & b);
         4'b0101: logic_res = ~b;
         4'b0110: logic_res = a ^ b;
         4'b0111: logic_res = a & ~b;
         4'b1000: logic_res = ~a | b;
         4'b1001: logic_res = ~(a ^ b);
         4'b1010: logic_res = b;
         4'b1011: logic_res = a & b;
         4'b1100: logic_res = 8'hFF;
         4'b1101: logic_res = a | ~b;
         4'b1110: logic_res = a | b;
         4'b1111: logic_res = a;
         default: logic_res = 8'h00;
      endcase
   end

   // Select between adder and logic result; carry-in only reaches the
   // outputs through the arithmetic branch so it cannot leak in logic mode
   always_comb begin
      sum    = {1'b0, p} + {1'b0, q} + {8'h00, c_in};
      f_next = 8'h00;
      c_next = 1'b0;
      if (m) begin
         f_next = logic_res;
         c_next = 1'b0;
      end else begin
         f_next = sum[7:0];
         c_next = sum[8];
      end
   end

   // Result registers: cleared by reset, loaded on accept, held otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f         <= 8'h00;
         c_out     <= 1'b0;
         a_eq_b    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            f      <= f_next;
            c_out  <= c_next;
            a_eq_b <= (a == b);
         end
      end
   end

`ifdef ULA_STATUS_FLAGS_EN
   logic ovf_next;

   // Signed overflow only has meaning for the adder path
   always_comb begin
      ovf_next = 1'b0;
      if (!m) begin
         ovf_next = (p[7] == q[7]) && (f_next[7] != p[7]);
      end
   end

   // Status flag registers follow the same accept/hold rule as the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero <= 1'b0;
         neg  <= 1'b0;
         ovf  <= 1'b0;
      end else if (in_valid) begin
         zero <= (f_next == 8'h00);
         neg  <= f_next[7];
         ovf  <= ovf_next;
      end
   end
`endif

endmodule

// File: tb/tb_ula_8bits.sv
// tb_ula_8bits: directed self-checking bench for ula_8bits with
// hand-computed expected values.
module tb_ula_8bits;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] s;
   logic       m;
   logic       c_in;
   logic [7:0] f;
   logic       c_out;
   logic       a_eq_b;
   logic       out_valid;
`ifdef ULA_STATUS_FLAGS_EN
   logic       zero;
   logic       neg;
   logic       ovf;
`endif

   int check_count  = 0;
   int passed_count = 0;

   // Sweep operands: a=3C, b=5A, c_in=1 (arithmetic) -- values worked by hand
   logic [7:0] arith_f [16] = '{8'h3D, 8'h97, 8'hE2, 8'h3C, 8'h79, 8'h7F, 8'hBE, 8'h18,
                                8'h55, 8'h61, 8'hA3, 8'h24, 8'hD6, 8'h5B, 8'h1E, 8'h00};
   logic       arith_c [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [7:0] logic_f [16] = '{8'hC3, 8'h81, 8'h42, 8'h00, 8'hE7, 8'hA5, 8'h66, 8'h24,
                                8'hDB, 8'h99, 8'h5A, 8'h18, 8'hFF, 8'hBD, 8'h7E, 8'h3C};

   ula_8bits dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .s         (s),
      .m         (m),
      .c_in      (c_in),
      .f         (f),
      .c_out     (c_out),
      .a_eq_b    (a_eq_b),
`ifdef ULA_STATUS_FLAGS_EN
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf),
`endif
      .out_valid (out_valid)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [8:0] actual, input logic [8:0] expected);
      check_count++;
      if (actual === expected) begin
         passed_count++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one set of operands and command inputs
   task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                                input logic tm, input logic tc, input logic tv);
      a        = ta;
      b        = tb;
      s        = ts;
      m        = tm;
      c_in     = tc;
      in_valid = tv;
   endtask

   // Advance to just after the next rising edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Directed test sequence
   initial begin
      rst = 1'b1;
      applyStimulus(8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("reset_f",     {1'b0, f},  9'h000);
      checkOutput("reset_cout",  {8'h00, c_out},     9'h000);
      checkOutput("reset_aeqb",  {8'h00, a_eq_b},    9'h000);
      checkOutput("reset_valid", {8'h00, out_valid}, 9'h000);
      stepCycle();
      stepCycle();
      rst = 1'b0;
      stepCycle();
      checkOutput("idle_f",      {1'b0, f},  9'h000);
      checkOutput("idle_valid",  {8'h00, out_valid}, 9'h000);

      // Carry propagation
      applyStimulus(8'h0F, 8'h01, 4'b0001, 1'b0, 1'b0, 1'b1);
      stepCycle();
      checkOutput("add_0f01_f",    {1'b0, f}, 9'h010);
      checkOutput("add_0f01_cout", {8'h00, c_out},     9'h000);
      checkOutput("add_0f01_vld",  {8'h00, out_valid}, 9'h001);
`ifdef ULA_STATUS_FLAGS_EN
      checkOutput("add_0f01_ovf",  {8'h00, ovf},       9'h000);
`endif
      applyStimulus(8'hFF, 8'h01, 4'b0001, 1'b0, 1'b0, 1'b1);
      stepCycle();
      checkOutput("add_ff01_f",    {1'b0, f}, 9'h000);
      checkOutput("add_ff01_cout", {8'h00, c_out},     9'h001);
`ifdef ULA_STATUS_FLAGS_EN
      checkOutput("add_ff01_zero", {8'h00, zero},      9'h001);
      checkOutput("add_ff01_ovf",  {8'h00, ovf},       9'h000);
      applyStimulus(8'h7F, 8'h01, 4'b0001, 1'b0, 1'b0, 1'b1);
      stepCycle();
      checkOutput("add_7f01_ovf",  {8'h00, ovf},       9'h001);
      checkOutput("add_7f01_neg",  {8'h00, neg},       9'h001);
`endif

      // Subtract with carry-in
      applyStimulus(8'hF0, 8'h1C, 4'b0010, 1'b0, 1'b1, 1'b1);
      stepCycle();
      checkOutput("sub_f01c_f",    {1'b0, f}, 9'h0D4);
      checkOutput("sub_f01c_cout", {8'h00, c_out},     9'h001);

      // Logic mode ignores carry-in
      applyStimulus(8'h3F, 8'h0A, 4'b0110, 1'b1, 1'b1, 1'b1);
      stepCycle();
      checkOutput("xor_f",         {1'b0, f}, 9'h035);
      checkOutput("xor_cout",      {8'h00, c_out},     9'h000);
      applyStimulus(8'h3F, 8'h0A, 4'b1011, 1'b1, 1'b1, 1'b1);
      stepCycle();
      checkOutput("and_f",         {1'b0, f}, 9'h00A);

      // Equality flag
      applyStimulus(8'hAA, 8'hAA, 4'b0101, 1'b1, 1'b0, 1'b1);
      stepCycle();
      checkOutput("eq_aa_aa",      {8'h00, a_eq_b},    9'h001);
      applyStimulus(8'hFF, 8'h01, 4'b0101, 1'b1, 1'b0, 1'b1);
      stepCycle();
      checkOutput("eq_ff_01",      {8'h00, a_eq_b},    9'h000);

      // Back-to-back sweep of all 32 functions
      for (int i = 0; i < 32; i++) begin
         logic [3:0] sel;
         logic       mode;
         sel  = i[3:0];
         mode = i[4];
         applyStimulus(8'h3C, 8'h5A, sel, mode, 1'b1, 1'b1);
         stepCycle();
         checkOutput($sformatf("sweep_m%0d_s%0d_f", mode, sel), {1'b0, f},
                     {1'b0, mode ? logic_f[sel] : arith_f[sel]});
         checkOutput($sformatf("sweep_m%0d_s%0d_c", mode, sel), {8'h00, c_out},
                     {8'h00, mode ? 1'b0 : arith_c[sel]});
         checkOutput($sformatf("sweep_m%0d_s%0d_v", mode, sel), {8'h00, out_valid}, 9'h001);
      end

      // Idle cycle holds the result (last sweep entry gave 3C) and drops valid
      applyStimulus(8'h11, 8'h22, 4'b0001, 1'b0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("hold_f",        {1'b0, f}, 9'h03C);
      checkOutput("hold_valid",    {8'h00, out_valid}, 9'h000);

      // Reset asserted mid-cycle with an accept pending
      applyStimulus(8'h0F, 8'h01, 4'b0001, 1'b0, 1'b0, 1'b1);
      stepCycle();
      checkOutput("pre_rst_f",     {1'b0, f}, 9'h010);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_f",   {1'b0, f}, 9'h000);
      checkOutput("async_rst_vld", {8'h00, out_valid}, 9'h000);
      applyStimulus(8'hAA, 8'hAA, 4'b0001, 1'b0, 1'b1, 1'b1);
      stepCycle();
      checkOutput("rst_win_f",     {1'b0, f}, 9'h000);
      checkOutput("rst_win_aeqb",  {8'h00, a_eq_b},    9'h000);
      checkOutput("rst_win_vld",   {8'h00, out_valid}, 9'h000);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'hAA, 8'hAA, 4'b0001, 1'b0, 1'b1, 1'b0);
      stepCycle();
      stepCycle();
      checkOutput("post_rst_f",    {1'b0, f}, 9'h000);
      checkOutput("post_rst_cout", {8'h00, c_out},     9'h000);
      checkOutput("post_rst_aeqb", {8'h00, a_eq_b},    9'h000);
      checkOutput("post_rst_vld",  {8'h00, out_valid}, 9'h000);

      $display("%0d/%0d checks passed", passed_count, check_count);
      $finish;
   end

endmodule

// File: doc/ula_8bits.md
Name:
ula_8bits

Overview:
- 8-bit registered ALU: 16 logic functions (m=1) and 16 arithmetic functions (m=0), for 32 functions selected by s/m.
- Also produces carry-out and an A==B compare flag.
- Sits in the datapath as a single-cycle-latency execution unit.
- Operands are sampled on the clock edge when in_valid is high; results are held in output registers until the next accepted operation.

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk      input   1  system clock; all state updates on the rising edge
- rst      input   1  asynchronous, active-high reset
- in_valid input   1  operand/command qualifier; operation accepted on a rising clk edge when high
- a        input   8  operand A
- b        input   8  operand B
- s        input   4  function select
- m        input   1  mode: 0 = arithmetic, 1 = logic
- c_in     input   1  carry-in, active-high; used in arithmetic mode only
- f        output  8  registered result
- c_out    output  1  registered carry-out, active-high
- a_eq_b   output  1  registered flag, 1 when a == b
- out_valid output 1  one-cycle pulse, high the cycle after an accepted operation

Behaviour:
- Reset (rst=1, asynchronous): f=8'h00, c_out=0, a_eq_b=0, out_valid=0 immediately, regardless of clk. Results stay cleared until the first accepted operation after rst deasserts.
- Latency and handshake:
  - On a rising clk edge with in_valid=1, compute from the current a/b/s/m/c_in; f, c_out, a_eq_b and out_valid=1 are visible after that edge.
  - Edge with in_valid=0: f, c_out and a_eq_b hold their values; out_valid=0.
  - No backpressure; back-to-back accepts every cycle are allowed.
- Arithmetic mode (m=0): 9-bit sum = P + Q + c_in, all unsigned; f = sum[7:0], c_out = sum[8]. P,Q by s:
  - 0000: A, 0
  - 0001: A, B
  - 0010: A, ~B (A-B when c_in=1)
  - 0011: A, FF (A-1+c_in)
  - 0100: A, A
  - 0101: A|B, 0
  - 0110: A|~B, 0
  - 0111: A&B, FF
  - 1000: A, A&B
  - 1001: A, A&~B
  - 1010: A|B, A&~B
  - 1011: A&~B, FF
  - 1100: A|~B, A&B
  - 1101: 0, B
  - 1110: ~A, B (B-A when c_in=1)
  - 1111: FF, 0
- Logic mode (m=1): c_in ignored, c_out=0. f by s:
  - 0000 ~A
  - 0001 ~(A|B)
  - 0010 ~A&B
  - 0011 00
  - 0100 ~(A&B)
  - 0101 ~B
  - 0110 A^B
  - 0111 A&~B
  - 1000 ~A|B
  - 1001 ~(A^B)
  - 1010 B
  - 1011 A&B
  - 1100 FF
  - 1101 A|~B
  - 1110 A|B
  - 1111 A
- a_eq_b: (a == b) of the accepted operands, independent of m/s/c_in.
- Wrap-around: an arithmetic result above FF wraps modulo 256, with c_out=1.
- Reset asserted mid-stream wins over any simultaneous accept; the operation in that cycle is discarded.
- Any X on unused inputs (c_in in logic mode) must not propagate to outputs.

Optional Feature:
- Macro ULA_STATUS_FLAGS_EN.
- Defined: adds registered outputs, updated on the same accept and cleared to 0 by reset:
  - zero (1 when the result f == 00)
  - neg (equal to f[7])
  - ovf (arithmetic mode only: P[7]==Q[7] and f[7]!=P[7]; 0 in logic mode)
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 mid-operation with in_valid=1 -> f=00, c_out=0, a_eq_b=0, out_valid=0 immediately; after release with in_valid=0, outputs stay 0.
- Carry propagation: m=0, s=0001, a=0F, b=01, c_in=0 -> f=10, c_out=0. Then a=FF, b=01 -> f=00, c_out=1.
- Subtract with carry: m=0, s=0010, a=F0, b=1C, c_in=1 -> f=D4, c_out=1.
- Logic mode: m=1, s=0110, a=3F, b=0A, c_in=1 -> f=35, c_out=0. Then s=1011 -> f=0A.
- Equality: a=AA, b=AA, any m/s -> a_eq_b=1. Then a=FF, b=01 -> a_eq_b=0.
- Handshake: sweep all 32 m/s combinations back-to-back with in_valid=1 -> each result appears exactly one cycle later. A cycle with in_valid=0 holds f and drops out_valid.
